// File: rtl/vc_request_issuer.sv
// vc_request_issuer: per-VC flit FIFOs with downstream credit tracking, raising switch-allocation requests and launching granted flits.
module vc_request_issuer #(
  parameter int NUM_VCS = 3,
  parameter int BUF_DEPTH = 4,
  parameter int CREDIT_MAX = 4,
  parameter int FLIT_WIDTH = 32,
  localparam int VC_W = NUM_VCS > 1 ? $clog2(NUM_VCS) : 1,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1),
  localparam int CR_W = $clog2(CREDIT_MAX + 1),
  localparam int PTR_W = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [VC_W-1:0]       in_vc,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  output logic [NUM_VCS-1:0]    requests,
  input  logic [NUM_VCS-1:0]    grants,
  input  logic                  credit_vld,
  input  logic [VC_W-1:0]       credit_vc,
  output logic                  out_valid,
  output logic [VC_W-1:0]       out_vc,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  err
);
  logic [FLIT_WIDTH-1:0] mem [NUM_VCS][BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_VCS];
  logic [PTR_W-1:0] wr_ptr [NUM_VCS];
  logic [CNT_W-1:0] count [NUM_VCS];
  logic [CR_W-1:0] credit [NUM_VCS];
  logic [NUM_VCS-1:0] wr, pop, ret, sat;
  logic gnt_ok, gnt_bad, cr_bad;
  logic [VC_W-1:0] pop_vc;
  logic [FLIT_WIDTH-1:0] pop_flit;
  // requests come from registered state only, so no loop forms through the arbiter
  always_comb begin
    requests = '0;
    for (int v = 0; v < NUM_VCS; v++)
      requests[v] = count[v] != '0 && credit[v] != '0;
  end
  always_comb begin
    in_ready = 1'b0;
    pop_vc = '0;
    pop_flit = '0;
    wr = '0;
    pop = '0;
    ret = '0;
    sat = '0;
    gnt_ok = grants != '0 && (grants & (grants - 1'b1)) == '0 && (grants & ~requests) == '0;
    gnt_bad = grants != '0 && !gnt_ok;
    cr_bad = credit_vld && {1'b0, credit_vc} >= (VC_W + 1)'(NUM_VCS);
    for (int v = 0; v < NUM_VCS; v++) begin
      in_ready |= in_vc == VC_W'(v) && count[v] != CNT_W'(BUF_DEPTH);
      wr[v] = in_valid && in_vc == VC_W'(v) && count[v] != CNT_W'(BUF_DEPTH);
      pop[v] = gnt_ok && grants[v];
      ret[v] = credit_vld && credit_vc == VC_W'(v);
      // a return at full credit only overflows if nothing is consumed in the same cycle
      sat[v] = ret[v] && !pop[v] && credit[v] == CR_W'(CREDIT_MAX);
      pop_vc = pop[v] ? VC_W'(v) : pop_vc;
      pop_flit = pop[v] ? mem[v][rd_ptr[v]] : pop_flit;
    end
  end
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++)
      if (wr[v]) mem[v][wr_ptr[v]] <= in_flit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v] <= '0;
        credit[v] <= CR_W'(CREDIT_MAX);
      end
      out_valid <= 1'b0;
      out_vc <= '0;
      out_flit <= '0;
      err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (wr[v]) wr_ptr[v] <= wr_ptr[v] == PTR_W'(BUF_DEPTH - 1) ? '0 : wr_ptr[v] + 1'b1;
        if (pop[v]) rd_ptr[v] <= rd_ptr[v] == PTR_W'(BUF_DEPTH - 1) ? '0 : rd_ptr[v] + 1'b1;
        count[v] <= count[v] + CNT_W'(wr[v]) - CNT_W'(pop[v]);
        credit[v] <= credit[v] + CR_W'(ret[v] & ~sat[v]) - CR_W'(pop[v]);
      end
      out_valid <= gnt_ok;
      if (gnt_ok) begin
        out_vc <= pop_vc;
        out_flit <= pop_flit;
      end
      if (gnt_bad || cr_bad || |sat) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vc_request_issuer.sv
// tb_vc_request_issuer: directed vector table, hand sequences and queue-model random traffic for vc_request_issuer.
module tb_vc_request_issuer;
  logic clk, reset, in_valid, in_ready, credit_vld, out_valid, err;
  logic [1:0] in_vc, credit_vc, out_vc;
  logic [31:0] in_flit, out_flit;
  logic [2:0] requests, grants;
  logic [2:0] pre_req;
  logic pre_rdy;
  int vectors, miscompares;

  vc_request_issuer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .in_ready(in_ready), .requests(requests), .grants(grants), .credit_vld(credit_vld),
    .credit_vc(credit_vc), .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst, iv;
    logic [1:0] ivc;
    logic [31:0] fl;
    logic [2:0] g;
    logic cv;
    logic [1:0] cvc;
    logic [2:0] req;
    logic rdy, ov;
    logic [1:0] ovc;
    logic [31:0] of;
    logic er;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, iv, input logic [1:0] ivc, input logic [31:0] fl,
                              input logic [2:0] g, input logic cv, input logic [1:0] cvc,
                              input logic [2:0] req, input logic rdy, ov, input logic [1:0] ovc,
                              input logic [31:0] of, input logic er);
    vec_t t;
    t = '{rst, iv, ivc, fl, g, cv, cvc, req, rdy, ov, ovc, of, er};
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // inputs are driven just after a rising edge; combinational outputs sampled mid-cycle, registers 1 after the next edge
  task automatic cyc(input logic r, iv, input logic [1:0] ivc, input logic [31:0] fl,
                     input logic [2:0] g, input logic cv, input logic [1:0] cvc);
    reset = r; in_valid = iv; in_vc = ivc; in_flit = fl; grants = g; credit_vld = cv; credit_vc = cvc;
    #2;
    pre_req = requests;
    pre_rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] q[3][$];
  int cr[3], outst[3];
  logic m_ov, m_err;
  logic [1:0] m_ovc;
  logic [31:0] m_of;

  task automatic model_reset();
    for (int v = 0; v < 3; v++) begin
      q[v].delete();
      cr[v] = 4;
      outst[v] = 0;
    end
    m_ov = 0; m_ovc = 0; m_of = 0; m_err = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1; in_valid = 0; in_vc = 0; in_flit = 0; grants = 0; credit_vld = 0; credit_vc = 0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0);

    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'hA1, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'hA2, 3'b000, 0, 0, 3'b010, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b010, 0, 0, 3'b010, 1, 1, 1, 32'hA1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b010, 0, 0, 3'b010, 1, 1, 1, 32'hA2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 1, 32'hA2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b011, 0, 0, 3'b000, 1, 0, 1, 32'hA2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 1, 32'hA2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 1, 0, 3'b000, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 1, 3, 3'b000, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b100, 0, 0, 3'b000, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h55, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 32'hB1, 3'b000, 0, 0, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b100, 0, 0, 3'b100, 1, 1, 2, 32'hB1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0, 2, 32'hB1, 0));
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].iv, tbl[i].ivc, tbl[i].fl, tbl[i].g, tbl[i].cv, tbl[i].cvc);
      chk($sformatf("t%0d_req", i), pre_req, tbl[i].req);
      chk($sformatf("t%0d_rdy", i), pre_rdy, tbl[i].rdy);
      chk($sformatf("t%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("t%0d_ovc", i), out_vc, tbl[i].ovc);
      chk($sformatf("t%0d_of", i), out_flit, tbl[i].of);
      chk($sformatf("t%0d_err", i), err, tbl[i].er);
    end

    // full FIFO: drop, blocked write alongside a pop, then accept
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 32'hC0 + i, 0, 0, 0);
      chk("fill_rdy", pre_rdy, 1);
    end
    cyc(0, 1, 0, 32'hC4, 0, 0, 0);
    chk("full_rdy", pre_rdy, 0);
    chk("full_req", pre_req, 3'b001);
    cyc(0, 1, 0, 32'hC5, 3'b001, 0, 0);
    chk("full_wg_rdy", pre_rdy, 0);
    chk("full_wg_ov", out_valid, 1);
    chk("full_wg_of", out_flit, 32'hC0);
    cyc(0, 1, 0, 32'hC6, 0, 0, 0);
    chk("refill_rdy", pre_rdy, 1);
    chk("refill_ov", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 3'b001, 0, 0);
      chk("drain_ov", out_valid, 1);
      chk("drain_of", out_flit, 32'hC1 + i);
    end
    idle();
    chk("nocredit_req", pre_req, 3'b000);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ret_req_same", pre_req, 3'b000);
    idle();
    chk("ret_req_next", pre_req, 3'b001);
    cyc(0, 0, 0, 0, 3'b001, 0, 0);
    chk("last_of", out_flit, 32'hC6);
    chk("seq0_err", err, 0);

    // simultaneous credit return and consume at credit 1
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 32'hD0 + i, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 3'b100, 0, 0);
    cyc(0, 0, 0, 0, 3'b100, 1, 2);
    chk("simret_of", out_flit, 32'hD3);
    chk("simret_err", err, 0);
    cyc(0, 1, 2, 32'hD4, 0, 0, 0);
    cyc(0, 1, 2, 32'hD5, 0, 0, 0);
    cyc(0, 0, 0, 0, 3'b100, 0, 0);
    chk("simret_req", pre_req, 3'b100);
    chk("simret_of2", out_flit, 32'hD4);
    idle();
    chk("simret_req0", pre_req, 3'b000);
    cyc(0, 0, 0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 3'b100, 0, 0);
    chk("midrst_req_pre", pre_req, 3'b100);
    chk("midrst_ov", out_valid, 0);
    idle();
    chk("midrst_req", pre_req, 3'b000);

    // random traffic against the queue model
    cyc(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, iv, cv, e_rdy;
      logic [1:0] ivc, cvc;
      logic [2:0] g, e_req;
      logic [31:0] fl;
      int k, v, p;
      for (int j = 0; j < 3; j++) e_req[j] = q[j].size() != 0 && cr[j] != 0;
      r = $urandom_range(0, 199) == 0;
      iv = $urandom_range(0, 9) < 6;
      ivc = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      fl = $urandom;
      e_rdy = ivc < 3 ? q[ivc].size() < 4 : 1'b0;
      k = $urandom_range(0, 99);
      g = 0;
      if (k < 1) g = 3'($urandom_range(1, 7));
      else if (k < 80 && e_req != 0) begin
        do v = $urandom_range(0, 2); while (!e_req[v]);
        g = 3'b001 << v;
      end
      k = $urandom_range(0, 99);
      v = $urandom_range(0, 2);
      cv = 0;
      cvc = 0;
      if (k < 1) begin
        cv = 1;
        cvc = 2'($urandom_range(0, 3));
      end else if (k < 40 && outst[v] > 0) begin
        cv = 1;
        cvc = 2'(v);
      end
      cyc(r, iv, ivc, fl, g, cv, cvc);
      chk("rnd_req", pre_req, e_req);
      chk("rnd_rdy", pre_rdy, e_rdy);
      if (r) model_reset();
      else begin
        p = -1;
        if ($countones(g) == 1 && (g & ~e_req) == 0) begin
          p = g == 3'b001 ? 0 : g == 3'b010 ? 1 : 2;
          m_of = q[p].pop_front();
          m_ovc = 2'(p);
          cr[p]--;
          outst[p]++;
        end else if (g != 0) m_err = 1;
        m_ov = p >= 0;
        if (iv && e_rdy) q[ivc].push_back(fl);
        if (cv) begin
          if (cvc > 2 || cr[cvc] == 4) m_err = 1;
          else begin
            cr[cvc]++;
            if (outst[cvc] > 0) outst[cvc]--;
          end
        end
      end
      chk("rnd_ov", out_valid, m_ov);
      chk("rnd_ovc", out_vc, m_ovc);
      chk("rnd_of", out_flit, m_of);
      chk("rnd_err", err, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
